// File: rtl/gate_pkg.sv
// Shared types for the basic-gate DUT family and the checker that grades them.
package gate_pkg;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_XOR  = 3'd2,
    GATE_NAND = 3'd3,
    GATE_NOR  = 3'd4,
    GATE_XNOR = 3'd5
  } gate_sel_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic sel_is_legal(input logic [2:0] sel);
    return sel <= 3'(GATE_XNOR);
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Golden combinational model of the six basic gates; illegal selects yield 0.
module gate_ref_model
  import gate_pkg::*;
(
  input  logic [2:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       expected
);

  always_comb begin
    // NOTE: default assigned first so no path leaves expected unassigned (no latch).
    expected = 1'b0;
    case (sel)
      GATE_AND:  expected = a & b;
      GATE_OR:   expected = a | b;
      GATE_XOR:  expected = a ^ b;
      GATE_NAND: expected = ~(a & b);
      GATE_NOR:  expected = ~(a | b);
      GATE_XNOR: expected = ~(a ^ b);
      default:   expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_response_checker.sv
// Grades a 2-input gate DUT: counts samples and mismatches, tracks input coverage,
// remembers the first failing input pair and produces a pass verdict per run.
module gate_response_checker
  import gate_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int N_CHECKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic             valid,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             sel_err,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       cov_mask,
  output logic             first_fail_vld,
  output logic [1:0]       first_fail_ab
);

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic               sel_err_q, sel_err_d;
  logic [CNT_W-1:0]   chk_q, chk_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [3:0]         cov_q, cov_d;
  logic               ffv_q, ffv_d;
  logic [1:0]         ffab_q, ffab_d;
  logic               expected;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  gate_ref_model u_ref (
    .sel      (sel_q),
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    sel_err_d = sel_err_q;
    chk_d     = chk_q;
    err_d     = err_q;
    cov_d     = cov_q;
    ffv_d     = ffv_q;
    ffab_d    = ffab_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // valid on the accepting edge is dropped: the new run starts empty
        if (start) begin
          sel_d     = gate_sel;
          sel_err_d = !sel_is_legal(gate_sel);
          chk_d     = '0;
          err_d     = '0;
          cov_d     = '0;
          ffv_d     = 1'b0;
          ffab_d    = '0;
          state_d   = sel_is_legal(gate_sel) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (valid) begin
          chk_d          = sat_inc(chk_q);
          cov_d[{a, b}]  = 1'b1;
          if (y != expected) begin
            err_d = sat_inc(err_q);
            if (!ffv_q) begin
              ffv_d  = 1'b1;
              ffab_d = {a, b};
            end
          end
          if (chk_q == CNT_W'(N_CHECKS - 1)) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: async reset clears every register, including the latched select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      sel_err_q <= 1'b0;
      chk_q     <= '0;
      err_q     <= '0;
      cov_q     <= '0;
      ffv_q     <= 1'b0;
      ffab_q    <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q   <= state_d;
      sel_q     <= sel_d;
      sel_err_q <= sel_err_d;
      chk_q     <= chk_d;
      err_q     <= err_d;
      cov_q     <= cov_d;
      ffv_q     <= ffv_d;
      ffab_q    <= ffab_d;
    end
  end

  assign busy           = (state_q == S_RUN);
  assign done           = (state_q == S_DONE);
  assign pass           = done && (err_q == '0) && (cov_q == 4'hF) && !sel_err_q;
  assign sel_err        = sel_err_q;
  assign chk_count      = chk_q;
  assign err_count      = err_q;
  assign cov_mask       = cov_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_ab  = ffab_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Self-checking bench for gate_response_checker: directed table, hand corner cases, random runs.
module tb_gate_response_checker;

  localparam int CNT_W    = 8;
  localparam int N_CHECKS = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [2:0]       gate_sel;
  logic             valid;
  logic             a;
  logic             b;
  logic             y;
  logic             busy;
  logic             done;
  logic             pass;
  logic             sel_err;
  logic [CNT_W-1:0] chk_count;
  logic [CNT_W-1:0] err_count;
  logic [3:0]       cov_mask;
  logic             first_fail_vld;
  logic [1:0]       first_fail_ab;

  int n_total = 0;
  int n_pass  = 0;

  gate_response_checker #(.CNT_W(CNT_W), .N_CHECKS(N_CHECKS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .gate_sel       (gate_sel),
    .valid          (valid),
    .a              (a),
    .b              (b),
    .y              (y),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .sel_err        (sel_err),
    .chk_count      (chk_count),
    .err_count      (err_count),
    .cov_mask       (cov_mask),
    .first_fail_vld (first_fail_vld),
    .first_fail_ab  (first_fail_ab)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] ab;      // four {a,b} pairs, first sample in the top bits
    logic [3:0] ys;      // four y values, first sample in the top bit
    logic [7:0] e_err;
    logic [3:0] e_cov;
    logic       e_pass;
    logic       e_ffv;
    logic [1:0] e_ffab;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] sel, input logic v);
    start    = 1'b1;
    gate_sel = sel;
    valid    = v;
    a        = 1'($urandom);
    b        = 1'($urandom);
    y        = 1'($urandom);
    step();
    start = 1'b0;
    valid = 1'b0;
  endtask

  task automatic sample(input logic [1:0] ab, input logic yy);
    valid  = 1'b1;
    {a, b} = ab;
    y      = yy;
    step();
    valid = 1'b0;
  endtask

  // Truth table per gate, bit index = {a,b}
  function automatic logic model_y(input logic [2:0] sel, input logic [1:0] ab);
    logic [3:0] tt;
    case (sel)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0110;
      3'd3: tt = 4'b0111;
      3'd4: tt = 4'b0001;
      3'd5: tt = 4'b1001;
      default: tt = 4'b0000;
    endcase
    return tt[ab];
  endfunction

  function automatic logic [31:0] all_outs();
    return {5'd0, busy, done, pass, sel_err, chk_count, err_count, cov_mask,
            first_fail_vld, first_fail_ab};
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b1; valid = 1'b1; gate_sel = 3'd1;
    a = 1'b1; b = 1'b0; y = 1'b1;

    // Reset with start/valid held high
    repeat (3) step();
    check("reset_all_zero", all_outs(), 32'd0);
    start = 1'b0; valid = 1'b0;
    rst_n = 1'b1;
    step();
    check("idle_after_reset", all_outs(), 32'd0);

    // Directed table
    tbl[0] = '{sel: 3'd1, ab: 8'b00_01_10_11, ys: 4'b0111, e_err: 8'd0, e_cov: 4'hF,
               e_pass: 1'b1, e_ffv: 1'b0, e_ffab: 2'b00};
    tbl[1] = '{sel: 3'd0, ab: 8'b00_01_10_11, ys: 4'b1111, e_err: 8'd3, e_cov: 4'hF,
               e_pass: 1'b0, e_ffv: 1'b1, e_ffab: 2'b00};
    tbl[2] = '{sel: 3'd2, ab: 8'b00_01_01_00, ys: 4'b0110, e_err: 8'd0, e_cov: 4'h3,
               e_pass: 1'b0, e_ffv: 1'b0, e_ffab: 2'b00};
    tbl[3] = '{sel: 3'd3, ab: 8'b11_10_01_00, ys: 4'b0110, e_err: 8'd1, e_cov: 4'hF,
               e_pass: 1'b0, e_ffv: 1'b1, e_ffab: 2'b00};
    tbl[4] = '{sel: 3'd5, ab: 8'b00_01_10_11, ys: 4'b1001, e_err: 8'd0, e_cov: 4'hF,
               e_pass: 1'b1, e_ffv: 1'b0, e_ffab: 2'b00};

    for (int v = 0; v < 5; v++) begin
      do_start(tbl[v].sel, 1'b0);
      check("tbl_busy_after_start", busy, 1);
      check("tbl_chk_after_start", chk_count, 0);
      for (int i = 0; i < 4; i++) begin
        if (i == 1) begin
          valid = 1'b0;
          step();
        end
        sample(tbl[v].ab[7-2*i -: 2], tbl[v].ys[3-i]);
        if (i < 3) check("tbl_busy_mid", busy, 1);
        check("tbl_chk_latency", chk_count, i + 1);
      end
      check("tbl_done", done, 1);
      check("tbl_busy_end", busy, 0);
      check("tbl_err", err_count, tbl[v].e_err);
      check("tbl_cov", cov_mask, tbl[v].e_cov);
      check("tbl_pass", pass, tbl[v].e_pass);
      check("tbl_ffv", first_fail_vld, tbl[v].e_ffv);
      check("tbl_ffab", first_fail_ab, tbl[v].e_ffab);
      sample(2'b11, ~model_y(tbl[v].sel, 2'b11));
      check("done_valid_ignored_chk", chk_count, 4);
      check("done_valid_ignored_err", err_count, tbl[v].e_err);
    end

    // Illegal select, then recovery with a legal one
    do_start(3'd7, 1'b0);
    check("illegal_done", done, 1);
    check("illegal_sel_err", sel_err, 1);
    check("illegal_pass", pass, 0);
    check("illegal_busy", busy, 0);
    check("illegal_cleared", {chk_count, err_count, cov_mask}, 0);
    do_start(3'd4, 1'b0);
    check("legal_after_illegal_busy", busy, 1);
    check("legal_after_illegal_sel_err", sel_err, 0);

    // start inside RUN is ignored
    sample(2'b00, 1'b1);
    sample(2'b01, 1'b1);
    check("mid_chk2", chk_count, 2);
    check("mid_err", err_count, 1);
    check("mid_ffab", first_fail_ab, 2'b01);
    do_start(3'd0, 1'b0);
    check("start_in_run_busy", busy, 1);
    check("start_in_run_chk", chk_count, 2);

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_mid_run", all_outs(), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_after_mid_reset", all_outs(), 32'd0);

    // Random runs against the reference model
    for (int r = 0; r < 30; r++) begin
      logic [2:0] sel;
      int         m_chk, m_err, budget;
      logic [3:0] m_cov;
      logic       m_ffv;
      logic [1:0] m_ffab;
      sel = 3'($urandom_range(0, 5));
      do_start(sel, 1'($urandom));
      check("rnd_start_chk0", chk_count, 0);
      m_chk = 0; m_err = 0; m_cov = 4'h0; m_ffv = 1'b0; m_ffab = 2'b00; budget = 0;
      while (m_chk < N_CHECKS && budget < 200) begin
        logic [1:0] ab;
        logic       yy, vv;
        ab = 2'($urandom);
        vv = ($urandom_range(0, 3) != 0);
        yy = ($urandom_range(0, 3) == 0) ? ~model_y(sel, ab) : model_y(sel, ab);
        valid = vv; {a, b} = ab; y = yy;
        if (($urandom_range(0, 7) == 0)) begin
          start = 1'b1;
          gate_sel = 3'($urandom);
        end
        step();
        valid = 1'b0; start = 1'b0;
        if (vv) begin
          m_chk++;
          m_cov[ab] = 1'b1;
          if (yy != model_y(sel, ab)) begin
            m_err++;
            if (!m_ffv) begin
              m_ffv  = 1'b1;
              m_ffab = ab;
            end
          end
          check("rnd_chk", chk_count, m_chk);
          check("rnd_err", err_count, m_err);
        end
        budget++;
      end
      check("rnd_budget", (m_chk == N_CHECKS), 1);
      check("rnd_done", done, 1);
      check("rnd_cov", cov_mask, m_cov);
      check("rnd_ffv", first_fail_vld, m_ffv);
      if (m_ffv) check("rnd_ffab", first_fail_ab, m_ffab);
      check("rnd_pass", pass, (m_err == 0) && (m_cov == 4'hF));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
